fpu_norm_round_stage: RTL and testbench
=======================================

Name: fpu_norm_round_stage

Overview:
- Pipelined FPU stage directly downstream of the mantissa add/subtract stage.
- Consumes the 25-bit raw mantissa sum, result sign, common (larger) exponent and guard/round/sticky bits.
- Normalises, rounds to nearest-even and packs an IEEE-754 single-precision word.
- Two internal register stages with valid/ready backpressure. Denormals are flushed to zero. Inf/NaN results computed upstream bypass the arithmetic.

Parameters:
- MANT_W, 24, mantissa width including hidden bit.
- EXP_W, 8, exponent width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- valid_i  in  1  input beat valid.
- ready_o  out  1  stage can accept a beat.
- mant_i  in  25  raw sum; bit 24 = carry, bit 23 = hidden-bit position.
- sign_i  in  1  result sign from sum stage.
- exp_i  in  8  common biased exponent.
- grs_i  in  3  guard, round, sticky bits from alignment.
- special_i  in  1  upstream detected Inf/NaN; bypass.
- special_val_i  in  32  packed special result.
- valid_o  out  1  output beat valid.
- ready_i  in  1  consumer accepts.
- result_o  out  32  packed float {sign, exp[7:0], frac[22:0]}.
- zero_o  out  1  result is ±0.
- overflow_o  out  1  rounded exponent reached 255 (result ±Inf).
- underflow_o  out  1  result flushed to zero from a nonzero sum.

Behaviour:
- Reset (async assert, sync release): both stage valids = 0; valid_o = 0; result_o = 0; all flags = 0; ready_o = 1 after release.
- Handshake:
  - Transfer on valid && ready.
  - Stage k advances when its successor is empty or transferring.
  - ready_o = !s1_valid || s1_advance (combinational on ready_i).
  - valid_o is registered.
  - Outputs hold stable while valid_o && !ready_i.
- Latency: 2 cycles with no stall. Throughput: 1 beat/cycle.
- Stage 1: capture inputs; compute lzc = leading-zero count of mant_i (0..25; 25 when mant_i == 0).
- Stage 2, normalise:
  - mant[24] = 1: shift {mant, grs} right 1; shifted-out bit ORs into sticky; exp+1.
  - mant == 0 and grs == 0: result +0 (sign forced 0 for exact cancellation); zero_o = 1.
  - Otherwise shift {mant, grs} (28 bits) left by (lzc - 1); zeros fill; exp -= (lzc - 1), computed signed 10-bit.
  - Normalised exp <= 0 (nonzero input): result ±0 with sign_i; underflow_o = 1; zero_o = 1.
- Stage 2, round (RNE):
  - up = g & (r | s | lsb).
  - Mantissa + up carrying to 2^24: mantissa = 0x800000; exp + 1.
- Stage 2, overflow: final exp >= 255 gives {sign, 8'hFF, 23'h0}; overflow_o = 1.
- Stage 2, special: special_i = 1 gives result_o = special_val_i, all flags 0, arithmetic ignored.
- Flags are valid only with valid_o.
- Reset mid-operation: in-flight beats are discarded; no output is produced for them.

Decomposition:
- float_types_pkg additions:
  - norm_in_t struct {mant[24:0], sign, exp, grs, special, special_val}.
  - Constants EXP_MAX = 255 and FRAC_W = 23.
- Sub-module lzc25: combinational 25-bit leading-zero counter, 5-bit output.

Test Plan:
- 1.0+1.0: mant_i = 25'h1000000, exp_i = 127, grs = 0 -> result_o = 32'h40000000, valid_o exactly 2 cycles after acceptance.
- Exact cancellation: mant_i = 0, grs = 0, sign_i = 1 -> 32'h00000000, zero_o = 1.
- RNE tie, lsb = 1: mant_i = 25'h0800001, exp_i = 127, grs = 3'b100 -> 32'h3F800002.
- RNE tie, lsb = 0: mant_i = 25'h0800000, grs = 3'b100 -> 32'h3F800000.
- Overflow: mant_i = 25'h1FFFFFE, exp_i = 254, sign_i = 0 -> 32'h7F800000, overflow_o = 1.
- Underflow: mant_i = 25'h0000001, exp_i = 10 -> 32'h00000000, underflow_o = 1.
- Backpressure: issue 3 back-to-back beats with ready_i = 0 for 3 cycles:
  - ready_o deasserts once both stages are full.
  - result_o stays stable while stalled.
  - All 3 results emerge in order with no loss or duplication.
- Async reset asserted with 2 beats in flight -> valid_o = 0 immediately and no stale beat appears after release.

Source files
------------

// File: rtl/float_types_pkg.sv
// rtl/float_types_pkg.sv - shared types and constants for the FPU normalise/round stage
package float_types_pkg;

    localparam int FRAC_W  = 23;
    localparam int EXP_MAX = 255;

    // One beat as captured by stage 1.
    typedef struct packed {
        logic [24:0] mant;
        logic        sign;
        logic [7:0]  exp;
        logic [2:0]  grs;
        logic        special;
        logic [31:0] special_val;
    } norm_in_t;

    // Packed result plus flags produced by stage 2.
    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic        overflow;
        logic        underflow;
    } norm_out_t;

endpackage

// File: rtl/fpu_norm_round_stage_lzc25.sv
// rtl/fpu_norm_round_stage_lzc25.sv - combinational 25-bit leading-zero counter
//
// Ports:
//   data_i  in  25  value to scan from bit 24 downwards
//   count_o out  5  number of leading zeros (0..25, 25 when data_i == 0)
module lzc25 (
    input  logic [24:0] data_i,
    output logic [4:0]  count_o
);

    logic found;

    always_comb begin
        count_o = 5'd25;
        found   = 1'b0;
        for (int i = 24; i >= 0; i--) begin
            if (!found && data_i[i]) begin
                count_o = 5'(24 - i);
                found   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_norm_round_stage.sv
// rtl/fpu_norm_round_stage.sv - two-stage normalise, round-to-nearest-even and pack
//
// Ports:
//   clk_i, rst_ni                 clock (rising edge), async active-low reset
//   valid_i / ready_o             input handshake
//   mant_i, sign_i, exp_i, grs_i  raw sum, sign, common exponent, guard/round/sticky
//   special_i, special_val_i      upstream Inf/NaN bypass and its packed value
//   valid_o / ready_i             output handshake
//   result_o                      packed single-precision result
//   zero_o, overflow_o, underflow_o  result flags, meaningful only with valid_o
module fpu_norm_round_stage
    import float_types_pkg::*;
#(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [MANT_W:0]   mant_i,
    input  logic              sign_i,
    input  logic [EXP_W-1:0]  exp_i,
    input  logic [2:0]        grs_i,
    input  logic              special_i,
    input  logic [31:0]       special_val_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [31:0]       result_o,
    output logic              zero_o,
    output logic              overflow_o,
    output logic              underflow_o
);

    // Stage 1 registers
    norm_in_t    s1_data_q, s1_data_d;
    logic [4:0]  s1_lzc_q, s1_lzc_d;
    logic        s1_valid_q, s1_valid_d;

    // Stage 2 (output) registers
    logic        valid_q, valid_d;
    norm_out_t   out_q, out_d;

    logic [4:0]  lzc_in;
    logic        s2_advance;
    norm_out_t   calc;

    // Stage 2 datapath
    logic [27:0]        ext;
    logic [27:0]        ext_n;
    logic [4:0]         shamt;
    logic signed [9:0]  exp_n;
    logic signed [9:0]  exp_r;
    logic [23:0]        m24;
    logic               g_bit, r_bit, s_bit, round_up;
    logic [24:0]        rnd;
    logic [FRAC_W-1:0]  frac_r;
    logic               unused_bits;

    lzc25 u_lzc (
        .data_i  (mant_i),
        .count_o (lzc_in)
    );

    always_comb begin
        ext    = {s1_data_q.mant, s1_data_q.grs};
        ext_n  = ext;
        shamt  = 5'd0;
        exp_n  = $signed({2'b00, s1_data_q.exp});

        if (s1_data_q.mant[24]) begin
            // Carry out of the adder: one right shift, the dropped bit folds into sticky.
            ext_n = {1'b0, ext[27:2], ext[1] | ext[0]};
            exp_n = $signed({2'b00, s1_data_q.exp}) + 10'sd1;
        end else begin
            // lzc >= 1 here; shifting by lzc-1 lands the leading one at the hidden bit.
            shamt = s1_lzc_q - 5'd1;
            ext_n = ext << shamt;
            exp_n = $signed({2'b00, s1_data_q.exp}) - $signed({5'b00000, shamt});
        end

        m24      = ext_n[26:3];
        g_bit    = ext_n[2];
        r_bit    = ext_n[1];
        s_bit    = ext_n[0];
        round_up = g_bit & (r_bit | s_bit | m24[0]);
        rnd      = {1'b0, m24} + {24'd0, round_up};

        if (rnd[24]) begin
            // Rounding carried to 2^24: mantissa becomes 1.0, exponent bumps.
            frac_r = '0;
            exp_r  = exp_n + 10'sd1;
        end else begin
            frac_r = rnd[FRAC_W-1:0];
            exp_r  = exp_n;
        end

        unused_bits = ^{rnd[23], ext_n[27]};

        calc = '0;
        if (s1_data_q.special) begin
            calc.result = s1_data_q.special_val;
        end else if (s1_data_q.mant == 25'd0 && s1_data_q.grs == 3'd0) begin
            // Exact cancellation always gives +0.
            calc.result = 32'h0000_0000;
            calc.zero   = 1'b1;
        end else if (exp_n <= 10'sd0) begin
            calc.result    = {s1_data_q.sign, 31'd0};
            calc.zero      = 1'b1;
            calc.underflow = 1'b1;
        end else if (exp_r >= 10'(EXP_MAX)) begin
            calc.result   = {s1_data_q.sign, 8'hFF, 23'd0};
            calc.overflow = 1'b1;
        end else begin
            calc.result = {s1_data_q.sign, exp_r[7:0], frac_r};
        end
    end

    always_comb begin
        s2_advance = !valid_q || ready_i;
        ready_o    = !s1_valid_q || s2_advance;

        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_lzc_d   = s1_lzc_q;
        if (ready_o) begin
            s1_valid_d = valid_i;
            if (valid_i) begin
                s1_data_d.mant        = mant_i;
                s1_data_d.sign        = sign_i;
                s1_data_d.exp         = exp_i;
                s1_data_d.grs         = grs_i;
                s1_data_d.special     = special_i;
                s1_data_d.special_val = special_val_i;
                s1_lzc_d              = lzc_in;
            end
        end

        valid_d = valid_q;
        out_d   = out_q;
        if (s2_advance) begin
            valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_d = calc;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_lzc_q   <= '0;
            valid_q    <= 1'b0;
            out_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_lzc_q   <= s1_lzc_d;
            valid_q    <= valid_d;
            out_q      <= out_d;
        end
    end

    assign valid_o     = valid_q;
    assign result_o    = out_q.result;
    assign zero_o      = out_q.zero;
    assign overflow_o  = out_q.overflow;
    assign underflow_o = out_q.underflow;

endmodule

// File: tb/tb_fpu_norm_round_stage.sv
// tb/tb_fpu_norm_round_stage.sv - self-checking bench for fpu_norm_round_stage
module tb_fpu_norm_round_stage;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [24:0] mant_i = '0;
    logic        sign_i = 1'b0;
    logic [7:0]  exp_i = '0;
    logic [2:0]  grs_i = '0;
    logic        special_i = 1'b0;
    logic [31:0] special_val_i = '0;
    logic        valid_o;
    logic        ready_i = 1'b1;
    logic [31:0] result_o;
    logic        zero_o, overflow_o, underflow_o;

    fpu_norm_round_stage #(.MANT_W(24), .EXP_W(8)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .mant_i        (mant_i),
        .sign_i        (sign_i),
        .exp_i         (exp_i),
        .grs_i         (grs_i),
        .special_i     (special_i),
        .special_val_i (special_val_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .result_o      (result_o),
        .zero_o        (zero_o),
        .overflow_o    (overflow_o),
        .underflow_o   (underflow_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        o;
        logic        u;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cycle = 0;
    int   last_acc = 0;

    always @(posedge clk_i) cycle++;

    // Reference: treat {mant,grs} as an integer scaled by 2^-26 relative to exp,
    // locate its top bit, keep 24 significant bits and round the remainder to even.
    function automatic exp_t model(input logic [24:0] m, input logic s, input logic [7:0] e,
                                   input logic [2:0] grs, input logic sp, input logic [31:0] spv);
        exp_t   r;
        longint x, kept, rem, half;
        int     p, ex;
        r.res = 32'd0; r.z = 1'b0; r.o = 1'b0; r.u = 1'b0;
        if (sp) begin
            r.res = spv;
            return r;
        end
        x = longint'({m, grs});
        if (x == 0) begin
            r.z = 1'b1;
            return r;
        end
        p = 0;
        for (int i = 0; i < 28; i++) if (x[i]) p = i;
        ex = int'(e) + p - 26;
        if (ex <= 0) begin
            r.res = {s, 31'd0}; r.z = 1'b1; r.u = 1'b1;
            return r;
        end
        if (p > 23) begin
            kept = x >> (p - 23);
            rem  = x & ((longint'(1) << (p - 23)) - 1);
            half = longint'(1) << (p - 24);
        end else begin
            kept = x << (23 - p);
            rem  = 0;
            half = 1;
        end
        if (rem > half || (rem == half && kept[0])) kept = kept + 1;
        if (kept == (longint'(1) << 24)) begin
            kept = kept >> 1;
            ex   = ex + 1;
        end
        if (ex >= 255) begin
            r.res = {s, 8'hFF, 23'd0}; r.o = 1'b1;
            return r;
        end
        r.res = {s, 8'(ex), kept[22:0]};
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Output compare: every valid cycle against the scoreboard, plus hold while stalled.
    logic [31:0] prev_res = '0;
    logic [2:0]  prev_flags = '0;
    logic        prev_stall = 1'b0;
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_checks++;
                if (!valid_o || result_o !== prev_res ||
                    {zero_o, overflow_o, underflow_o} !== prev_flags) begin
                    n_fail++;
                    $display("FAIL hold: valid=%b result=%h flags=%b expected valid=1 result=%h flags=%b",
                             valid_o, result_o, {zero_o, overflow_o, underflow_o}, prev_res, prev_flags);
                end
            end
            if (valid_o) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat: result=%h with no beat outstanding", result_o);
                end else if (result_o !== exp_q[0].res || zero_o !== exp_q[0].z ||
                             overflow_o !== exp_q[0].o || underflow_o !== exp_q[0].u) begin
                    n_fail++;
                    $display("FAIL beat: got result=%h z=%b o=%b u=%b expected result=%h z=%b o=%b u=%b",
                             result_o, zero_o, overflow_o, underflow_o,
                             exp_q[0].res, exp_q[0].z, exp_q[0].o, exp_q[0].u);
                end
                if (ready_i && exp_q.size() > 0) void'(exp_q.pop_front());
            end
            prev_stall = valid_o && !ready_i;
            prev_res   = result_o;
            prev_flags = {zero_o, overflow_o, underflow_o};
        end
    end

    // Present one beat (called just after a rising edge) and hold it until accepted.
    task automatic send(input logic [24:0] m, input logic s, input logic [7:0] e,
                        input logic [2:0] g, input logic sp, input logic [31:0] spv);
        int waited = 0;
        bit done = 0;
        mant_i = m; sign_i = s; exp_i = e; grs_i = g; special_i = sp; special_val_i = spv;
        valid_i = 1'b1;
        while (!done) begin
            @(negedge clk_i);
            if (ready_o) begin
                exp_q.push_back(model(m, s, e, g, sp, spv));
                last_acc = cycle;
                done = 1;
            end else if (++waited > 50) begin
                n_checks++; n_fail++;
                $display("FAIL accept_timeout: ready_o low for %0d cycles, expected acceptance", waited);
                done = 1;
            end
            @(posedge clk_i); #1;
        end
        valid_i = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while ((exp_q.size() != 0 || valid_o) && w < 200) begin
            @(posedge clk_i); w++;
        end
        #1;
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    exp_t mr;
    int   acc0;

    initial begin
        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_valid_o", {31'd0, valid_o}, 32'd0);
        chk("rst_result_o", result_o, 32'd0);
        chk("rst_flags", {29'd0, zero_o, overflow_o, underflow_o}, 32'd0);
        #2 rst_ni = 1'b1;
        @(posedge clk_i); #1;
        chk("rst_ready_o", {31'd0, ready_o}, 32'd1);

        // Pin the reference against hand-computed values
        mr = model(25'h1000000, 1'b0, 8'd127, 3'b000, 1'b0, 32'd0);
        chk("model_one_plus_one", mr.res, 32'h40000000);
        mr = model(25'h0800001, 1'b0, 8'd127, 3'b100, 1'b0, 32'd0);
        chk("model_tie_odd", mr.res, 32'h3F800002);
        mr = model(25'h1FFFFFE, 1'b0, 8'd254, 3'b000, 1'b0, 32'd0);
        chk("model_overflow", {mr.res[31:1], mr.o}, {31'h3FC00000, 1'b1});
        mr = model(25'h0FFFFFF, 1'b0, 8'd100, 3'b100, 1'b0, 32'd0);
        chk("model_round_carry", mr.res, 32'h32800000);
        mr = model(25'h1000001, 1'b0, 8'd127, 3'b001, 1'b0, 32'd0);
        chk("model_shift_sticky", mr.res, 32'h40000001);

        // 1.0 + 1.0 and its latency
        send(25'h1000000, 1'b0, 8'd127, 3'b000, 1'b0, 32'd0);
        acc0 = last_acc;
        @(negedge clk_i);
        chk("latency_c1", {31'd0, valid_o}, 32'd0);
        @(negedge clk_i);
        chk("latency_c2", {31'd0, valid_o}, 32'd1);
        chk("latency_cycles", 32'(cycle - acc0), 32'd2);
        chk("one_plus_one", result_o, 32'h40000000);
        @(posedge clk_i); #1;
        drain();

        // Directed vectors, back-to-back
        send(25'h0000000, 1'b1, 8'd90,  3'b000, 1'b0, 32'd0);          // exact cancellation
        send(25'h0800001, 1'b0, 8'd127, 3'b100, 1'b0, 32'd0);          // tie, lsb 1
        send(25'h0800000, 1'b0, 8'd127, 3'b100, 1'b0, 32'd0);          // tie, lsb 0
        send(25'h1FFFFFE, 1'b0, 8'd254, 3'b000, 1'b0, 32'd0);          // overflow
        send(25'h0000001, 1'b0, 8'd10,  3'b000, 1'b0, 32'd0);          // underflow
        send(25'h0000001, 1'b1, 8'd10,  3'b000, 1'b0, 32'd0);          // underflow, negative
        send(25'h1234567, 1'b1, 8'd255, 3'b111, 1'b1, 32'h7FC00000);   // special bypass
        send(25'h0000300, 1'b1, 8'd100, 3'b000, 1'b0, 32'd0);          // large left shift
        send(25'h0FFFFFF, 1'b0, 8'd100, 3'b100, 1'b0, 32'd0);          // rounding carry
        send(25'h1000001, 1'b0, 8'd127, 3'b000, 1'b0, 32'd0);          // shifted-out tie, even
        send(25'h1000001, 1'b0, 8'd127, 3'b001, 1'b0, 32'd0);          // shifted-out, sticky
        send(25'h1FFFFFF, 1'b1, 8'd253, 3'b110, 1'b0, 32'd0);          // round into overflow
        send(25'h0400000, 1'b0, 8'd1,   3'b000, 1'b0, 32'd0);          // exp reaches 0
        send(25'h0400000, 1'b0, 8'd2,   3'b000, 1'b0, 32'd0);          // smallest normal
        drain();

        // Mixed vectors with a randomly toggling consumer
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    logic [24:0] m;
                    logic [2:0]  g;
                    m = 25'($urandom) >> $urandom_range(0, 24);
                    g = 3'($urandom);
                    if (m == 25'd0) g = 3'd0;
                    send(m, 1'($urandom), 8'($urandom_range(1, 254)), g, 1'b0, 32'd0);
                end
            end
            begin
                repeat (60) begin
                    @(posedge clk_i); #1;
                    ready_i = 1'($urandom);
                end
                ready_i = 1'b1;
            end
        join
        drain();

        // Backpressure: three beats with the consumer stalled for three cycles
        ready_i = 1'b0;
        fork
            begin
                send(25'h0C00000, 1'b0, 8'd127, 3'b000, 1'b0, 32'd0);
                send(25'h0A00000, 1'b1, 8'd130, 3'b010, 1'b0, 32'd0);
                send(25'h1800000, 1'b0, 8'd60,  3'b101, 1'b0, 32'd0);
            end
            begin
                repeat (3) @(posedge clk_i);
                #1 ready_i = 1'b1;
            end
            begin
                @(posedge clk_i); @(posedge clk_i); @(negedge clk_i);
                chk("bp_ready_low", {31'd0, ready_o}, 32'd0);
            end
        join
        drain();

        // Reset with two beats in flight
        ready_i = 1'b0;
        send(25'h1000000, 1'b0, 8'd127, 3'b000, 1'b0, 32'd0);
        send(25'h0900000, 1'b0, 8'd127, 3'b000, 1'b0, 32'd0);
        #2 rst_ni = 1'b0;
        #1;
        chk("rst_mid_valid_o", {31'd0, valid_o}, 32'd0);
        exp_q.delete();
        ready_i = 1'b1;
        @(posedge clk_i); #3 rst_ni = 1'b1;
        begin
            int seen = 0;
            repeat (10) begin
                @(negedge clk_i);
                if (valid_o) seen++;
            end
            chk("rst_no_stale", 32'(seen), 32'd0);
        end
        chk("rst_ready_after", {31'd0, ready_o}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
